uart_tx_sched: RTL and testbench

- Shares one UART serial transmit line between NREQ byte sources.
- Round-robin arbiter picks a requester; a tick-sequenced FSM then serialises the byte as 8N1 (or 8N2) frames.
- Bit timing comes from an external one-clk-wide baud tick, produced by the existing tick generator (e.g. max=2604, one tick per bit).
- Sits between game/debug logic producing bytes and the board TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_sched.sv | 128 ++++++++++++
 tb/tb_uart_tx_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   uart_state_t  : frame sequencer states
//   BAUD_TICK_MAX : default divider of the external tick generator (one tick per bit)
//   frame_len()   : bit periods per frame (start + data + stop)
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int BAUD_TICK_MAX = 2604;

    function automatic int frame_len(input int data_w, input int stop_bits);
        return data_w + 1 + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   last      : index of the most recent grant; search starts at last+1
//   enable    : gates the one-hot grant output
//   grant     : one-hot grant (zero when disabled or no request)
//   grant_idx : index of the selected requester (valid when any=1)
//   any       : at least one request is present
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int   cand;
    int   sel;
    logic hit;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester (last+1) wins without needing an early exit.
    always_comb begin
        cand = 0;
        sel  = 0;
        hit  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last) + k) % NREQ;
            if (req[cand[IDX_W-1:0]]) begin
                sel = cand;
                hit = 1'b1;
            end
        end
        any       = hit;
        grant_idx = sel[IDX_W-1:0];
        grant     = (enable && hit) ? (NREQ'(1) << sel) : '0;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmit line between NREQ byte sources.
// A round-robin arbiter picks a requester on a baud tick; the frame is then
// shifted out LSB first as start + DATA_W data + STOP_BITS stop bits.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : one-cycle baud pulse, one per bit period
//   req_valid  : per-requester byte available
//   req_data   : requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot accept pulse (combinational)
//   tx         : registered serial line, idle high
//   busy       : frame in progress
//   grant_id   : index of the last accepted requester
import uart_pkg::*;

module uart_tx_sched #(
    parameter int NREQ      = 2,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id
);

    localparam int CNT_W = $clog2(DATA_W);

    uart_state_t                       state, state_next;
    logic [DATA_W-1:0]                 shreg;
    logic [CNT_W-1:0]                  bit_cnt;
    logic                              stop_cnt;
    logic [IDX_W-1:0]                  last_ptr;
    logic [NREQ-1:0][DATA_W-1:0]       req_bytes;

    logic                              data_last, stop_last, window, accept, any_req;
    logic [NREQ-1:0]                   grant;
    logic [IDX_W-1:0]                  grant_idx;

    assign req_bytes = req_data;
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

    // A new byte may only be taken on a tick while idle or on the final stop
    // tick, which makes back-to-back frames run with no idle bit between them.
    assign window = tick && ((state == ST_IDLE) || ((state == ST_STOP) && stop_last));
    assign accept = window && any_req;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .last      (last_ptr),
        .enable    (window),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state
    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                ST_IDLE:  if (accept) state_next = ST_START;
                ST_START: state_next = ST_DATA;
                ST_DATA:  if (data_last) state_next = ST_STOP;
                ST_STOP:  if (stop_last) state_next = accept ? ST_START : ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready = grant;
        busy      = (state != ST_IDLE);
    end

    // Shifter, counters and line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            grant_id <= '0;
            last_ptr <= IDX_W'(NREQ - 1);
        end else if (accept) begin
            shreg    <= req_bytes[grant_idx];
            grant_id <= grant_idx;
            last_ptr <= grant_idx;
            tx       <= 1'b0;
        end else if (tick) begin
            unique case (state)
                ST_START: begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (data_last) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!stop_last) stop_cnt <= stop_cnt + 1'b1;
                    tx <= 1'b1;
                end
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: two scheduler instances (2 req / 1 stop, 3 req / 2 stop),
// each with its own driver, a frame-level reference model and a serial decoder
// that pops expected bytes from a scoreboard queue.
module tb_uart_tx_sched;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int NR = (g == 0) ? 2 : 3;
        localparam int SB = (g == 0) ? 1 : 2;
        localparam int IW = (NR > 1) ? $clog2(NR) : 1;
        localparam int FL = DW + 1 + SB;   // bit periods per frame

        logic             reset = 1'b1;
        logic             tick  = 1'b0;
        logic [NR-1:0]    req_valid = '0;
        logic [NR*DW-1:0] req_data  = '0;
        logic [NR-1:0]    req_ready;
        logic             tx, busy;
        logic [IW-1:0]    grant_id;

        uart_tx_sched #(.NREQ(NR), .DATA_W(DW), .STOP_BITS(SB)) dut (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .req_valid (req_valid),
            .req_data  (req_data),
            .req_ready (req_ready),
            .tx        (tx),
            .busy      (busy),
            .grant_id  (grant_id)
        );

        // Reference model state: ticks until the line may take a new byte.
        int            m_left = 0;
        int            m_last = NR - 1;
        int            m_gid  = 0;
        bit            exp_tx0 = 1'b0;
        exp_t          exp_q[$];
        logic [NR-1:0] acc = '0;
        // Serial decoder
        int            dec_n = 0;
        logic [7:0]    dec_byte = '0;

        int tick_mode = 0;
        int tcnt = 0;
        bit keep = 1'b0, rnd = 1'b0, rst_rand = 1'b0, done = 1'b0;

        always @(negedge clk) begin
            logic [NR-1:0] exp_rdy;
            exp_rdy = '0;
            if (reset) begin
                m_left = 0; m_last = NR - 1; m_gid = 0; exp_tx0 = 1'b0;
                exp_q.delete(); dec_n = 0; acc = '0;
            end else begin
                chk(busy === (m_left > 0), "busy", longint'(busy), longint'(m_left > 0));
                chk(grant_id === IW'(m_gid), "grant_id", longint'(grant_id), longint'(m_gid));
                if (exp_tx0)        chk(tx === 1'b0, "tx_fall", longint'(tx), 0);
                else if (m_left == 0) chk(tx === 1'b1, "tx_idle", longint'(tx), 1);
                exp_tx0 = 1'b0;

                // Decode: the value on tx during a tick cycle is the bit ending at that tick.
                if (tick) begin
                    if (dec_n == 0) begin
                        if (tx === 1'b0) begin dec_n = 1; dec_byte = '0; end
                    end else if (dec_n <= DW) begin
                        dec_byte[dec_n-1] = tx;
                        dec_n++;
                    end else begin
                        chk(tx === 1'b1, "stop_bit", longint'(tx), 1);
                        if (dec_n == DW + SB) begin
                            if (exp_q.size() == 0) begin
                                chk(1'b0, "frame_unexpected", longint'(dec_byte), 0);
                            end else begin
                                exp_t e;
                                e = exp_q.pop_front();
                                chk(dec_byte === e.data, "frame_data", longint'(dec_byte), longint'(e.data));
                                chk(grant_id === IW'(e.id), "frame_id", longint'(grant_id), longint'(e.id));
                            end
                            dec_n = 0;
                        end else dec_n++;
                    end
                end

                // Acceptance: only on a tick once the previous frame's bit periods are spent.
                if (tick) begin
                    if (m_left > 0) m_left--;
                    if (m_left == 0 && req_valid != '0) begin
                        int pick;
                        pick = -1;
                        for (int k = 1; k <= NR && pick < 0; k++)
                            if (req_valid[(m_last + k) % NR]) pick = (m_last + k) % NR;
                        exp_rdy[pick] = 1'b1;
                        exp_q.push_back('{id: pick, data: req_data[pick*DW +: DW]});
                        m_last = pick; m_gid = pick; m_left = FL; exp_tx0 = 1'b1;
                    end
                end
                chk(req_ready === exp_rdy, "req_ready", longint'(req_ready), longint'(exp_rdy));
                acc = req_valid & req_ready;
            end
        end

        task automatic step();
            @(posedge clk); #1;
            case (tick_mode)
                0: begin tcnt = (tcnt == 3) ? 0 : tcnt + 1; tick = (tcnt == 3); end
                1: tick = 1'b1;
                default: tick = 1'($urandom_range(0, 1));
            endcase
            if (rst_rand) reset = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) req_valid[i] = keep;
                if (rnd) begin
                    if (!req_valid[i] && $urandom_range(0, 99) < 20) begin
                        req_valid[i] = 1'b1;
                        req_data[i*DW +: DW] = DW'($urandom);
                    end else if (req_valid[i] && !acc[i] && $urandom_range(0, 99) < 3) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        endtask

        task automatic run(input int n);
            repeat (n) step();
        endtask

        task automatic set_req(input int i, input logic [7:0] d);
            req_data[i*DW +: DW] = d;
            req_valid[i] = 1'b1;
        endtask

        task automatic drain();
            int c;
            req_valid = '0;
            c = 0;
            while ((m_left != 0 || exp_q.size() != 0) && c < 400) begin step(); c++; end
            chk(c < 400, "drain_timeout", longint'(c), 400);
        endtask

        task automatic align_tick();
            int c;
            c = 0;
            while (!tick && c < 8) begin step(); c++; end
            step();   // the tick has now been consumed
        endtask

        task automatic wait_acc(input int i);
            int c;
            c = 0;
            do begin step(); c++; end while (!acc[i] && c < 100);
            chk(c < 100, "wait_accept", longint'(c), 100);
        endtask

        initial begin
            tick_mode = (g == 0) ? 0 : 1;
            run(3);
            reset = 1'b0;
            if (g == 0) begin
                set_req(0, 8'hA5);                       // single frame
                run(60); drain();
                set_req(0, 8'h11); set_req(1, 8'h22);    // round-robin, continuous valid
                keep = 1'b1; run(4 * FL * 4 + 8); keep = 1'b0; drain();
                align_tick(); set_req(1, 8'h5A);          // late request
                run(60); drain();
                set_req(0, 8'h3C); wait_acc(0);          // reset in the middle of a frame
                run(18); reset = 1'b1; step(); reset = 1'b0;
                set_req(0, 8'h96); run(60); drain();
                align_tick(); set_req(1, 8'hC3);          // valid dropped between ticks
                step(); req_valid[1] = 1'b0; run(20);
                rnd = 1'b1; rst_rand = 1'b1; run(1500);
                tick_mode = 2; run(1500);
                rnd = 1'b0; rst_rand = 1'b0; reset = 1'b0; drain();
            end else begin
                set_req(0, 8'hFF); run(30); drain();     // tick every cycle, two stop bits
                set_req(0, 8'h81); set_req(2, 8'h7E);
                keep = 1'b1; run(6 * FL); keep = 1'b0; drain();
                tick_mode = 2; rnd = 1'b1; run(2500); rnd = 1'b0; drain();
            end
            chk(exp_q.size() == 0, "queue_empty", longint'(exp_q.size()), 0);
            done = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(h[0].done && h[1].done) && c < 60000) begin @(posedge clk); c++; end
        checks++;
        if (!(h[0].done && h[1].done)) begin
            failures++;
            $display("FAIL bench_timeout actual=%0d expected<%0d", c, 60000);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
